disp_demux_rx: RTL and testbench

DISP_DEMUX_RX -- requirements
Module: disp_demux_rx

---
 rtl/disp_demux_rx.sv | 190 +++++++++++++++++++
 tb/tb_disp_demux_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/disp_demux_rx.sv
// disp_demux_rx
//   Receives a time-multiplexed 7-segment display bus that alternates between
//   a floor digit and a people-count digit. The receiver waits for the bus to
//   settle after each slot change, samples it once and decodes the digit. An
//   output is only updated after MATCH consecutive identical valid samples.
//   If the multiplexer stops toggling for TMO cycles, both outputs are
//   invalidated, but their last values are kept.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   phase      in   asynchronous slot select (1 = floor slot, 0 = people slot)
//   disp[7:0]  in   segments a..g on [6:0] (active-high), dp on [7]
//   floor[1:0] out  last accepted floor number
//   people[2:0]out  last accepted people count
//   floor_vld  out  floor holds an accepted value
//   people_vld out  people holds an accepted value
//   upd        out  one-cycle pulse when an output changes or becomes valid
//   err        out  one-cycle pulse on an invalid sample
module disp_demux_rx #(
  parameter int SETTLE = 4,
  parameter int MATCH  = 2,
  parameter int TMO    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phase,
  input  logic [7:0] disp,
  output logic [1:0] floor,
  output logic [2:0] people,
  output logic       floor_vld,
  output logic       people_vld,
  output logic       upd,
  output logic       err
);

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0]  MATCH_C     = 3'(MATCH);
  localparam logic [15:0] TMO_C       = 16'(TMO);
  localparam logic [15:0] TMO_LAST    = 16'(TMO - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

  // Returns {ok, digit}; ok=0 for dp set or a pattern outside the table.
  function automatic logic [3:0] seg_decode(input logic [7:0] d);
    logic [3:0] r;
    r = 4'b0000;
    if (!d[7]) begin
      case (d[6:0])
        7'h3F: r = 4'b1000;
        7'h06: r = 4'b1001;
        7'h5B: r = 4'b1010;
        7'h4F: r = 4'b1011;
        7'h66: r = 4'b1100;
        7'h6D: r = 4'b1101;
        7'h7D: r = 4'b1110;
        7'h07: r = 4'b1111;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c >= MATCH_C) ? MATCH_C : c + 3'd1;
  endfunction

  state_t      state, state_n;
  logic        ph_m, ph_s, ph_d;
  logic        chg;
  logic        slot;
  logic [3:0]  scnt;
  logic [7:0]  samp_p1;
  logic [15:0] tcnt;
  logic        tmo_hit;
  logic [1:0]  cand_f;
  logic [2:0]  cand_p;
  logic [2:0]  mc_f, mc_p;

  logic [3:0]  dec;
  logic [2:0]  digit;
  logic        ok;
  logic        cap;
  logic [2:0]  mc_f_n, mc_p_n;

  assign chg     = ph_s ^ ph_d;
  assign tmo_hit = !chg && (tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Any slot change, in any state, restarts the settle window for the new slot.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (chg) state_n = ST_SETTLE;
      ST_SETTLE:  if (chg) state_n = ST_SETTLE;
                  else if (scnt == SETTLE_LAST) state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = chg ? ST_SETTLE : ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    dec    = seg_decode(samp_p1);
    digit  = dec[2:0];
    ok     = dec[3] && !(slot && digit[2]);
    cap    = (state == ST_CAPTURE) && !chg;
    mc_f_n = (digit[1:0] == cand_f) ? sat_inc(mc_f) : 3'd1;
    mc_p_n = (digit == cand_p)      ? sat_inc(mc_p) : 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_m       <= 1'b0;
      ph_s       <= 1'b0;
      ph_d       <= 1'b0;
      slot       <= 1'b0;
      scnt       <= '0;
      samp_p1    <= '0;
      tcnt       <= '0;
      cand_f     <= '0;
      cand_p     <= '0;
      mc_f       <= '0;
      mc_p       <= '0;
      floor      <= '0;
      people     <= '0;
      floor_vld  <= 1'b0;
      people_vld <= 1'b0;
      upd        <= 1'b0;
      err        <= 1'b0;
    end else begin
      // stage 0: phase synchroniser and slot-change timing
      ph_m <= phase;
      ph_s <= ph_m;
      ph_d <= ph_s;
      if (chg) begin
        slot <= ph_s;
        scnt <= '0;
        tcnt <= '0;
      end else begin
        if (state == ST_SETTLE) scnt <= scnt + 4'd1;
        if (tcnt != TMO_C)      tcnt <= tcnt + 16'd1;
      end

      // stage 1: bus sample taken on the edge that enters CAPTURE
      if ((state == ST_SETTLE) && !chg && (scnt == SETTLE_LAST))
        samp_p1 <= disp;

      // stage 2: match filter and output update
      upd <= 1'b0;
      err <= 1'b0;
      if (cap) begin
        if (!ok) begin
          err <= 1'b1;
          if (slot) mc_f <= '0;
          else      mc_p <= '0;
        end else if (slot) begin
          cand_f <= digit[1:0];
          mc_f   <= mc_f_n;
          if ((mc_f_n == MATCH_C) && (!floor_vld || (digit[1:0] != floor))) begin
            floor     <= digit[1:0];
            floor_vld <= 1'b1;
            upd       <= 1'b1;
          end
        end else begin
          cand_p <= digit;
          mc_p   <= mc_p_n;
          if ((mc_p_n == MATCH_C) && (!people_vld || (digit != people))) begin
            people     <= digit;
            people_vld <= 1'b1;
            upd        <= 1'b1;
          end
        end
      end

      // Timeout wins over a coincident update so no upd is seen with vld low.
      if (tmo_hit) begin
        floor_vld  <= 1'b0;
        people_vld <= 1'b0;
        mc_f       <= '0;
        mc_p       <= '0;
        upd        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_demux_rx.sv
// tb_disp_demux_rx
//   Directed bench for disp_demux_rx with default parameters
//   (SETTLE=4, MATCH=2, TMO=256). Drives display slots of 32 cycles and
//   checks outputs and pulse counts against hand-computed values.
module tb_disp_demux_rx;

  logic       clk;
  logic       rst_n;
  logic       phase;
  logic [7:0] disp;
  logic [1:0] floor;
  logic [2:0] people;
  logic       floor_vld;
  logic       people_vld;
  logic       upd;
  logic       err;

  int nvec = 0;
  int nerr = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int u0, e0;

  disp_demux_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase      (phase),
    .disp       (disp),
    .floor      (floor),
    .people     (people),
    .floor_vld  (floor_vld),
    .people_vld (people_vld),
    .upd        (upd),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd)        upd_cnt++;
    if (err)        err_cnt++;
    if (upd && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slot_drv(input logic ph, input logic [7:0] d);
    @(negedge clk);
    phase = ph;
    disp  = d;
    repeat (32) @(negedge clk);
  endtask

  task automatic mark;
    u0 = upd_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    phase = 1'b0;
    disp  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_floor",      32'(floor), 0);
    chk("rst_people",     32'(people), 0);
    chk("rst_floor_vld",  32'(floor_vld), 0);
    chk("rst_people_vld", 32'(people_vld), 0);
    chk("rst_upd",        32'(upd), 0);
    chk("rst_err",        32'(err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_pulse", 32'(upd_cnt + err_cnt), 0);

    // invalid samples: digit 4 in floor slot, dp set, unknown pattern
    mark();
    slot_drv(1'b1, 8'h66);
    chk("err_digit4", 32'(err_cnt - e0), 1);
    chk("err_digit4_vld", 32'(floor_vld), 0);
    slot_drv(1'b0, 8'h86);
    slot_drv(1'b1, 8'h86);
    slot_drv(1'b0, 8'h40);
    chk("err_total", 32'(err_cnt - e0), 4);
    chk("err_no_upd", 32'(upd_cnt - u0), 0);
    chk("err_vlds", 32'({floor_vld, people_vld}), 0);

    // basic capture: floor 3, people 6, update on second capture of each
    mark();
    slot_drv(1'b1, 8'h4F);
    slot_drv(1'b0, 8'h7D);
    chk("first_pass_upd", 32'(upd_cnt - u0), 0);
    chk("first_pass_vld", 32'({floor_vld, people_vld}), 0);
    slot_drv(1'b1, 8'h4F);
    chk("floor_3", 32'(floor), 3);
    chk("floor_3_vld", 32'(floor_vld), 1);
    slot_drv(1'b0, 8'h7D);
    chk("people_6", 32'(people), 6);
    chk("people_6_vld", 32'(people_vld), 1);
    chk("basic_upd", 32'(upd_cnt - u0), 2);
    slot_drv(1'b1, 8'h4F);
    slot_drv(1'b0, 8'h7D);
    chk("repeat_no_upd", 32'(upd_cnt - u0), 2);
    chk("basic_no_err", 32'(err_cnt - e0), 0);

    // phase glitch inside the settle window
    mark();
    @(negedge clk);
    phase = 1'b1;
    disp  = 8'h00;
    repeat (2) @(negedge clk);
    phase = 1'b0;
    disp  = 8'h7D;
    repeat (32) @(negedge clk);
    chk("glitch_no_err", 32'(err_cnt - e0), 0);
    chk("glitch_no_upd", 32'(upd_cnt - u0), 0);
    chk("glitch_floor", 32'(floor), 3);

    // clean slots after the glitch: floor 2 accepted, then alternating 1/2
    slot_drv(1'b1, 8'h5B);
    slot_drv(1'b0, 8'h7D);
    slot_drv(1'b1, 8'h5B);
    chk("floor_2", 32'(floor), 2);
    chk("floor_2_upd", 32'(upd_cnt - u0), 1);
    mark();
    for (int i = 0; i < 4; i++) begin
      slot_drv(1'b0, 8'h7D);
      slot_drv(1'b1, (i % 2 == 0) ? 8'h06 : 8'h5B);
    end
    slot_drv(1'b0, 8'h7D);
    chk("alt_floor", 32'(floor), 2);
    chk("alt_no_upd", 32'(upd_cnt - u0), 0);
    chk("alt_no_err", 32'(err_cnt - e0), 0);

    // timeout with phase held, then revalidation
    mark();
    repeat (300) @(negedge clk);
    chk("tmo_vlds", 32'({floor_vld, people_vld}), 0);
    chk("tmo_floor_kept", 32'(floor), 2);
    chk("tmo_people_kept", 32'(people), 6);
    chk("tmo_no_upd", 32'(upd_cnt - u0), 0);
    slot_drv(1'b1, 8'h5B);
    slot_drv(1'b0, 8'h7D);
    chk("tmo_first_still_invalid", 32'({floor_vld, people_vld}), 0);
    slot_drv(1'b1, 8'h5B);
    slot_drv(1'b0, 8'h7D);
    chk("tmo_revalid", 32'({floor_vld, people_vld}), 3);
    chk("tmo_revalid_upd", 32'(upd_cnt - u0), 2);

    // reset asserted during SETTLE
    @(negedge clk);
    phase = 1'b1;
    disp  = 8'h4F;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_floor", 32'(floor), 0);
    chk("arst_people", 32'(people), 0);
    chk("arst_vlds", 32'({floor_vld, people_vld}), 0);
    phase = 1'b0;
    disp  = 8'h00;
    repeat (3) @(negedge clk);
    mark();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_err", 32'(err_cnt - e0), 0);
    chk("arst_no_upd", 32'(upd_cnt - u0), 0);
    chk("arst_outs", 32'({floor, people, floor_vld, people_vld}), 0);

    chk("upd_err_exclusive", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
